// File: rtl/ring_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ring_scan_controller
//  Purpose  : Steps a one-hot select across a 4:1 mux, holds each enabled
//             channel for DWELL_CYCLES clocks, captures the mux output at the
//             end of each dwell and flags sample / frame completion.
//  Revision : 1.0 - initial release
// ============================================================================
module ring_scan_controller #(
    parameter int DWELL_CYCLES = 1000,
    parameter int CNT_W        = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] channel_mask,
    input  logic       mux_out,
    output logic [3:0] ring_counter,
    output logic [3:0] samples,
    output logic       sample_valid,
    output logic [1:0] sample_channel,
    output logic       frame_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_cur;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ring;
    logic [3:0]       r_samples;
    logic             r_sample_valid;
    logic [1:0]       r_sample_channel;
    logic             r_frame_done;

    logic [1:0]       w_first;
    logic [1:0]       w_next;
    logic             w_has_next;
    logic [1:0]       w_target;
    logic             w_last;

    // Lowest enabled channel, and lowest enabled channel above the current one
    always_comb begin
        w_first    = 2'd0;
        w_next     = 2'd0;
        w_has_next = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (channel_mask[i]) begin
                w_first = 2'(i);
                if (2'(i) > r_cur) begin
                    w_next     = 2'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    assign w_target = w_has_next ? w_next : w_first;
    assign w_last   = (r_cnt == C_LAST);

    // Scan sequencer: dwell counting, channel stepping, capture and pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_cur            <= 2'd0;
            r_cnt            <= '0;
            r_ring           <= 4'b0000;
            r_samples        <= 4'b0000;
            r_sample_valid   <= 1'b0;
            r_sample_channel <= 2'd0;
            r_frame_done     <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ring <= 4'b0000;
                    r_cnt  <= '0;
                    if (enable && (|channel_mask)) begin
                        r_state <= ST_DWELL;
                        r_cur   <= w_first;
                        r_ring  <= 4'(4'b0001 << w_first);
                    end
                end
                ST_DWELL: begin
                    if (w_last) begin
                        // Capture always completes, even if the mask or enable
                        // changed during the dwell.
                        r_samples[r_cur] <= mux_out;
                        r_sample_channel <= r_cur;
                        r_sample_valid   <= 1'b1;
                        r_frame_done     <= ~w_has_next;
                        r_cnt            <= '0;
                        if (!enable || (channel_mask == 4'b0000)) begin
                            r_state <= ST_IDLE;
                            r_ring  <= 4'b0000;
                        end else begin
                            r_cur  <= w_target;
                            r_ring <= 4'(4'b0001 << w_target);
                        end
                    end else if (!enable) begin
                        // Abort before capture: drop the select, keep samples
                        r_state <= ST_IDLE;
                        r_ring  <= 4'b0000;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ring  <= 4'b0000;
                end
            endcase
        end
    end

    assign ring_counter   = r_ring;
    assign samples        = r_samples;
    assign sample_valid   = r_sample_valid;
    assign sample_channel = r_sample_channel;
    assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ring_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_scan_controller
//  Purpose  : Directed bench for ring_scan_controller (dwell 4 and dwell 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_scan_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] channel_mask;
    logic [3:0] pattern;
    logic       mux_out, mux_out1;
    logic [3:0] ring_counter, samples, ring1, samples1;
    logic       sample_valid, frame_done, sv1, fd1;
    logic [1:0] sample_channel, sch1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    assign mux_out  = |(ring_counter & pattern);
    assign mux_out1 = |(ring1 & pattern);

    ring_scan_controller #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .channel_mask(channel_mask), .mux_out(mux_out),
        .ring_counter(ring_counter), .samples(samples),
        .sample_valid(sample_valid), .sample_channel(sample_channel),
        .frame_done(frame_done)
    );

    ring_scan_controller #(.DWELL_CYCLES(1), .CNT_W(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .channel_mask(channel_mask), .mux_out(mux_out1),
        .ring_counter(ring1), .samples(samples1),
        .sample_valid(sv1), .sample_channel(sch1),
        .frame_done(fd1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One active edge, then land on the following falling edge
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        enable  = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] pat;
        logic [3:0] exp_samples;
        logic [1:0] exp_fch;
        int         exp_period;
        int         exp_svpf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int illegal, zero_ring, fd_wo_sv, fch_bad, per_bad, svpf_bad, run_bad, frames;
        int last_fd, svc, runlen;
        logic [3:0] prev_ring;
        int quiet_bad;

        vecs[0] = '{4'b1111, 4'b1010, 4'b1010, 2'd3, 16, 4};
        vecs[1] = '{4'b0101, 4'b1111, 4'b0101, 2'd2,  8, 2};
        vecs[2] = '{4'b0100, 4'b0100, 4'b0100, 2'd2,  4, 1};
        vecs[3] = '{4'b1010, 4'b0110, 4'b0010, 2'd3,  8, 2};
        vecs[4] = '{4'b1001, 4'b1001, 4'b1001, 2'd3,  8, 2};

        reset_n      = 1'b1;
        enable       = 1'b0;
        channel_mask = 4'b0000;
        pattern      = 4'b0000;

        // Reset state
        do_reset();
        check("reset_ring",    32'(ring_counter),   32'h0);
        check("reset_samples", 32'(samples),        32'h0);
        check("reset_sv",      32'(sample_valid),   32'h0);
        check("reset_sch",     32'(sample_channel), 32'h0);
        check("reset_fd",      32'(frame_done),     32'h0);

        // Table-driven free-running scans
        for (int v = 0; v < 5; v++) begin
            do_reset();
            channel_mask = vecs[v].mask;
            pattern      = vecs[v].pat;
            enable       = 1'b1;
            illegal = 0; zero_ring = 0; fd_wo_sv = 0; fch_bad = 0;
            per_bad = 0; svpf_bad = 0; run_bad = 0; frames = 0;
            last_fd = -1; svc = 0; runlen = 0; prev_ring = 4'b0000;
            for (int c = 1; c <= 70; c++) begin
                step();
                if (($countones(ring_counter) > 1) || ((ring_counter & ~vecs[v].mask) != 4'b0000))
                    illegal++;
                if (ring_counter == 4'b0000) zero_ring++;
                if (ring_counter == prev_ring) runlen++;
                else begin
                    if (prev_ring != 4'b0000 && runlen != 4) run_bad++;
                    runlen = 1;
                end
                prev_ring = ring_counter;
                if (sample_valid) svc++;
                if (frame_done) begin
                    frames++;
                    if (!sample_valid) fd_wo_sv++;
                    if (sample_channel != vecs[v].exp_fch) fch_bad++;
                    if (last_fd >= 0 && (c - last_fd) != vecs[v].exp_period) per_bad++;
                    if (svc != vecs[v].exp_svpf) svpf_bad++;
                    last_fd = c;
                    svc = 0;
                end
            end
            check($sformatf("v%0d_ring_legal", v),   32'(illegal),   32'd0);
            check($sformatf("v%0d_ring_nonzero", v), 32'(zero_ring), 32'd0);
            check($sformatf("v%0d_dwell_len", v),    32'(run_bad),   32'd0);
            check($sformatf("v%0d_fd_with_sv", v),   32'(fd_wo_sv),  32'd0);
            check($sformatf("v%0d_fd_channel", v),   32'(fch_bad),   32'd0);
            check($sformatf("v%0d_fd_period", v),    32'(per_bad),   32'd0);
            check($sformatf("v%0d_sv_per_frame", v), 32'(svpf_bad),  32'd0);
            check($sformatf("v%0d_frames", v),       32'(frames),    32'(69 / vecs[v].exp_period));
            check($sformatf("v%0d_samples", v),      32'(samples),   32'(vecs[v].exp_samples));
        end

        // Dwell of 1: channel advances every cycle; dwell 4 holds
        do_reset();
        channel_mask = 4'b1111;
        pattern      = 4'b0000;
        enable       = 1'b1;
        step(); check("d1_ring_c0", 32'(ring1), 32'b0001); check("d4_ring_c0", 32'(ring_counter), 32'b0001);
        step(); check("d1_ring_c1", 32'(ring1), 32'b0010); check("d1_sv_c1", 32'(sv1), 32'd1);
        step(); check("d1_ring_c2", 32'(ring1), 32'b0100);
        step(); check("d1_ring_c3", 32'(ring1), 32'b1000);
        step(); check("d1_ring_c4", 32'(ring1), 32'b0001); check("d1_fd_c4", 32'(fd1), 32'd1);
        check("d4_ring_c4", 32'(ring_counter), 32'b0010);

        // Abort on cycle 2 of the channel-1 dwell, then restart
        do_reset();
        channel_mask = 4'b1111;
        pattern      = 4'b0001;
        enable       = 1'b1;
        for (int k = 0; k < 6; k++) step();   // ch0 captured, ch1 at count 1
        check("abort_pre_ring", 32'(ring_counter), 32'b0010);
        check("abort_pre_samples", 32'(samples), 32'b0001);
        enable = 1'b0;
        step();
        check("abort_ring", 32'(ring_counter), 32'b0000);
        check("abort_sv", 32'(sample_valid), 32'd0);
        check("abort_samples", 32'(samples), 32'b0001);
        enable = 1'b1;
        step();
        check("restart_ring", 32'(ring_counter), 32'b0001);
        quiet_bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (sample_valid) quiet_bad++;
        end
        check("restart_no_early_sv", 32'(quiet_bad), 32'd0);
        step();
        check("restart_sv", 32'(sample_valid), 32'd1);
        check("restart_sch", 32'(sample_channel), 32'd0);

        // Mask shrinks while dwelling on channel 2
        do_reset();
        channel_mask = 4'b1111;
        pattern      = 4'b1111;
        enable       = 1'b1;
        for (int k = 0; k < 10; k++) step();  // ch2 at count 1
        check("mchg_pre_ring", 32'(ring_counter), 32'b0100);
        channel_mask = 4'b0011;
        step(); step(); step();
        check("mchg_sv",      32'(sample_valid),   32'd1);
        check("mchg_sch",     32'(sample_channel), 32'd2);
        check("mchg_fd",      32'(frame_done),     32'd1);
        check("mchg_ring",    32'(ring_counter),   32'b0001);
        check("mchg_samples", 32'(samples),        32'b0111);

        // Asynchronous reset between clock edges
        do_reset();
        channel_mask = 4'b1111;
        pattern      = 4'b1111;
        enable       = 1'b1;
        for (int k = 0; k < 6; k++) step();
        #1 reset_n = 1'b0;
        #1;
        check("areset_ring",    32'(ring_counter),   32'h0);
        check("areset_samples", 32'(samples),        32'h0);
        check("areset_sv",      32'(sample_valid),   32'h0);
        check("areset_sch",     32'(sample_channel), 32'h0);
        check("areset_fd",      32'(frame_done),     32'h0);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("areset_restart_ring", 32'(ring_counter), 32'b0001);

        // Empty mask: stays idle with enable high
        do_reset();
        channel_mask = 4'b0000;
        enable       = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ring_counter != 4'b0000 || sample_valid || frame_done) quiet_bad++;
        end
        check("empty_mask_idle", 32'(quiet_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
